// File: rtl/mem_stage_lsu_pkg.sv
// rtl/mem_stage_lsu_pkg.sv - shared RV32I load/store encodings, LSU FSM states and lane helpers
package mem_stage_lsu_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Halfword lanes follow addr[1] only, so an odd halfword address still lands on an aligned lane pair.
  function automatic logic [3:0] store_bmask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_SB:   return 4'b0001 << off;
      F3_SH:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3)
      F3_SB:   return {4{wdata[7:0]}};
      F3_SH:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LH, F3_LHU: return off[0];
      F3_LW:         return |off;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// rtl/mem_stage_lsu_load_align.sv - lsu_load_align: selects and extends the load lane from a read word
module lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_result = i_rdata;
    case (i_funct3)
      F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_result = {24'd0, w_byte};
      F3_LH:   o_result = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_result = {16'd0, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - M-stage load/store unit with IDLE/WAIT handshake FSM and WB registers
// Optional misaligned-access trap enabled by LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_addr_M,
  input  logic [31:0] i_wdata_M,
  input  logic [2:0]  i_funct3_M,
  input  logic        i_memwren_M,
  input  logic        i_memrden_M,
  input  logic        i_insnvld_M,
  input  logic        i_rdwren_M,
  input  logic [4:0]  i_rd_addr_M,
  input  logic [31:0] i_alu_M,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_bmask,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall_M,
  output logic [31:0] o_wbdata_WB,
  output logic [4:0]  o_rd_addr_WB,
  output logic        o_rdwren_WB,
  output logic        o_insnvld_WB
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        o_misalign_WB
`endif
);

  lsu_state_e  r_state;
  lsu_state_e  w_next_state;
  logic        w_memop;
  logic        w_misalign;
  logic        w_issue;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_bmask;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] w_load_data;
  logic [31:0] w_wb_data;

  assign w_memop = i_insnvld_M & (i_memwren_M | i_memrden_M);

`ifdef LSU_MISALIGN_TRAP_EN
  // A trapped access never enters WAIT; it retires straight to WB flagged as misaligned.
  assign w_misalign = (r_state == ST_IDLE) & w_memop & is_misaligned(i_funct3_M, i_addr_M[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue = w_memop & ~w_misalign;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_issue) w_next_state = ST_WAIT;
      ST_WAIT: if (i_dmem_ack) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_dmem_req = (r_state == ST_WAIT);
    o_stall_M  = ((r_state == ST_IDLE) & w_issue) | ((r_state == ST_WAIT) & ~i_dmem_ack);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_bmask  <= '0;
      r_we     <= 1'b0;
      r_funct3 <= '0;
    end else if ((r_state == ST_IDLE) && w_issue) begin
      r_addr   <= i_addr_M;
      r_wdata  <= store_wdata(i_funct3_M, i_wdata_M);
      r_bmask  <= store_bmask(i_funct3_M, i_addr_M[1:0]);
      r_we     <= i_memwren_M;
      r_funct3 <= i_funct3_M;
    end
  end

  assign o_dmem_addr  = {r_addr[31:2], 2'b00};
  assign o_dmem_wdata = r_wdata;
  assign o_dmem_bmask = r_bmask;
  assign o_dmem_we    = r_we;

  lsu_load_align u_load_align (
    .i_rdata  (i_dmem_rdata),
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_result (w_load_data)
  );

  // The only unstalled WAIT cycle is the ack cycle, so read data is captured exactly then.
  assign w_wb_data = ((r_state == ST_WAIT) && !r_we) ? w_load_data : i_alu_M;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wbdata_WB   <= '0;
      o_rd_addr_WB  <= '0;
      o_rdwren_WB   <= 1'b0;
      o_insnvld_WB  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      o_misalign_WB <= 1'b0;
`endif
    end else if (o_stall_M) begin
      o_wbdata_WB   <= '0;
      o_rd_addr_WB  <= '0;
      o_rdwren_WB   <= 1'b0;
      o_insnvld_WB  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      o_misalign_WB <= 1'b0;
`endif
    end else begin
      o_wbdata_WB   <= w_wb_data;
      o_rd_addr_WB  <= i_rd_addr_M;
      o_rdwren_WB   <= i_rdwren_M & ~w_misalign;
      o_insnvld_WB  <= i_insnvld_M;
`ifdef LSU_MISALIGN_TRAP_EN
      o_misalign_WB <= w_misalign;
`endif
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL: i_clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL: i_rst_n  in  1  reset, asynchronous and active-low.
REQ-003 SHALL: i_addr_M  in  32  effective address (ALU result from EX/M register).
REQ-004 SHALL: i_wdata_M  in  32  store data (rs2 from EX/M register).
REQ-005 SHALL: i_funct3_M  in  3  access size/sign (RV32I load/store funct3).
REQ-006 SHALL: i_memwren_M / i_memrden_M  in  1 each  store / load request.
REQ-007 SHALL: i_insnvld_M, i_rdwren_M  in  1 each; i_rd_addr_M  in  5; i_alu_M  in  32  pass-through M-stage fields.
REQ-008 SHALL: o_dmem_req, o_dmem_we  out  1 each; o_dmem_addr  out  32, bits[1:0]=0; o_dmem_wdata  out  32; o_dmem_bmask  out  4.
REQ-009 SHALL: i_dmem_ack  in  1  request accepted and read data valid; i_dmem_rdata  in  32  word read data.
REQ-010 SHALL: o_stall_M  out  1  freeze IF..M stages.
REQ-011 SHALL: o_wbdata_WB  out  32; o_rd_addr_WB  out  5; o_rdwren_WB, o_insnvld_WB  out  1 each  registered WB-stage fields.

Function
REQ-012 SHALL: FSM states IDLE, WAIT; memop = i_insnvld_M & (i_memwren_M | i_memrden_M).
REQ-013 SHALL: IDLE & memop -> latch addr/wdata/bmask/we/funct3, go WAIT; no request in IDLE cycle.
REQ-014 SHALL: WAIT holds o_dmem_req=1 with latched fields stable until i_dmem_ack; ack -> IDLE.
REQ-015 SHALL: o_stall_M = (IDLE & memop) | (WAIT & !i_dmem_ack), combinational.
REQ-016 SHALL: WB registers load on rising edge when o_stall_M=0; while stalled load bubble (o_rdwren_WB=0, o_insnvld_WB=0).
REQ-017 SHALL: o_wbdata_WB = aligned load data for loads, i_alu_M otherwise; minimum load latency 2 cycles M-entry to WB-valid.
REQ-018 SHALL: store mask SB 4'b0001<<addr[1:0], SH 4'b0011<<{addr[1],1'b0}, SW 4'b1111; byte/half data replicated across lanes.
REQ-019 SHALL: loads LB/LH sign-extend, LBU/LHU zero-extend the lane selected by addr[1:0]; LW whole word.
REQ-020 SHALL: i_dmem_ack in IDLE ignored; back-to-back memops each take own IDLE->WAIT pass.

Reset
REQ-021 SHALL: reset asserted -> FSM IDLE, o_dmem_req=0, all WB outputs 0, latched fields 0, immediately and regardless of state.
REQ-022 SHALL: reset mid-WAIT abandons request; later ack dropped.

Configuration
REQ-023 SHALL: macro LSU_MISALIGN_TRAP_EN defined -> port o_misalign_WB (out 1) added; SH/LH/LHU with addr[0]=1 or SW/LW with addr[1:0]!=0 issue no request, no stall, WB gets o_misalign_WB=1, o_rdwren_WB=0 for one cycle.
REQ-024 SHALL: macro undefined -> no port, misaligned access proceeds with REQ-018 mask from addr low bits.

Structure
REQ-025 SHALL: shared package holds funct3 encodings (LB..LHU, SB..SW) and FSM state enum.
REQ-026 SHALL: combinational sub-module lsu_load_align (rdata, addr[1:0], funct3 -> 32-bit result) instantiated once.

Verification
REQ-027 SHALL: SW addr 0x100 data 0xDEADBEEF, ack after 3 cycles -> bmask 1111, addr 0x100, stall 4 cycles, req held stable.
REQ-028 SHALL: LB addr 0x203, rdata 0x80112233, immediate ack -> o_wbdata_WB 0xFFFFFF80, rdwren_WB=1, 2-cycle latency.
REQ-029 SHALL: SH addr 0x302 data 0x0000ABCD -> bmask 1100, wdata 0xABCDABCD.
REQ-030 SHALL: non-memory ADD result 0x55 -> o_wbdata_WB 0x55 next cycle, no stall, no req.
REQ-031 SHALL: reset pulse during WAIT, then stray ack -> req low, FSM IDLE, WB outputs 0.
REQ-032 SHALL: with LSU_MISALIGN_TRAP_EN, LW addr 0x101 -> no req, o_misalign_WB=1 one cycle, rdwren_WB=0.
